// File: rtl/digit_scan.sv
// digit_scan: four-digit time-multiplexed display scanner with a prescaled slot timer.
// Define DIGIT_SCAN_BLANK_EN to compile in leading-zero blanking of digits 3..1.
module digit_scan #(
    parameter int BIT    = 4,
    parameter int DIVIDE = 100000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [4*BIT-1:0] in,
    input  logic [3:0]       dp_in,
    output logic [BIT-1:0]   digit,
    output logic [3:0]       an,
    output logic             dp,
    output logic             tick
);

    localparam int            CW   = $clog2(DIVIDE);
    localparam logic [CW-1:0] LAST = CW'(DIVIDE - 1);

    logic [CW-1:0]  cnt;
    logic [1:0]     idx;
    logic [BIT-1:0] field;
    logic [3:0]     an_sel;
    logic           wrap;

    assign wrap = (cnt == LAST);

    always_comb begin
        field = in[BIT-1:0];
        case (idx)
            2'd0: field = in[0*BIT +: BIT];
            2'd1: field = in[1*BIT +: BIT];
            2'd2: field = in[2*BIT +: BIT];
            2'd3: field = in[3*BIT +: BIT];
            default: field = in[BIT-1:0];
        endcase
        an_sel      = 4'b1111;
        an_sel[idx] = 1'b0;
    end

`ifdef DIGIT_SCAN_BLANK_EN
    logic zero3, zero2, zero1, blank;

    // zeroK: every field from K up to 3 is zero; digit 0 is never a candidate
    assign zero3 = (in[3*BIT +: BIT] == '0);
    assign zero2 = zero3 && (in[2*BIT +: BIT] == '0);
    assign zero1 = zero2 && (in[1*BIT +: BIT] == '0);
    assign blank = ((idx == 2'd3 && zero3) || (idx == 2'd2 && zero2) ||
                    (idx == 2'd1 && zero1)) && !dp_in[idx];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            idx   <= 2'd0;
            digit <= '0;
            an    <= 4'b1111;
            dp    <= 1'b1;
            tick  <= 1'b0;
        end else if (en) begin
            if (wrap) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            tick  <= wrap;
            digit <= field;
            dp    <= ~dp_in[idx];
`ifdef DIGIT_SCAN_BLANK_EN
            an    <= blank ? 4'b1111 : an_sel;
`else
            an    <= an_sel;
`endif
        end else begin
            // counters hold so the scan resumes mid-slot; display goes dark
            digit <= '0;
            an    <= 4'b1111;
            dp    <= 1'b1;
            tick  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_digit_scan.sv
// tb_digit_scan: directed vector table plus hand-written reset, gap and blanking sequences.
// Blanking expectations follow DIGIT_SCAN_BLANK_EN when the bench is built with it.
module tb_digit_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] in;
    logic [3:0]  dp_in;
    logic [3:0]  digit;
    logic [3:0]  an;
    logic        dp;
    logic        tick;

    int pass_cnt  = 0;
    int total_cnt = 0;

    digit_scan #(.BIT(4), .DIVIDE(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .in    (in),
        .dp_in (dp_in),
        .digit (digit),
        .an    (an),
        .dp    (dp),
        .tick  (tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] in;
        logic [3:0]  dp_in;
        logic        en;
        logic [3:0]  an;
        logic [3:0]  digit;
        logic        dp;
        logic        tick;
    } vec_t;

    vec_t tbl[48];

    function automatic vec_t v(logic [15:0] i, logic [3:0] d, logic e,
                               logic [3:0] a, logic [3:0] g, logic p, logic t);
        vec_t r;
        r.in = i; r.dp_in = d; r.en = e; r.an = a; r.digit = g; r.dp = p; r.tick = t;
        return r;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        else
            pass_cnt++;
    endtask

    // at most one anode low, every cycle including reset and gaps
    always @(negedge clk) begin
        total_cnt++;
        if ($countones(~an) > 1)
            $display("FAIL onehot_an at %0t: got %b expected at most one zero", $time, an);
        else
            pass_cnt++;
    end

    logic [3:0] blk_an[4];
    logic [3:0] blk_dg[4];

    initial begin
        // rows: in, dp_in, en | an, digit, dp, tick
        tbl[0]  = v(16'h1234, 4'b0000, 1, 4'b1110, 4, 1, 0);
        tbl[1]  = v(16'h1234, 4'b0000, 1, 4'b1110, 4, 1, 0);
        tbl[2]  = v(16'h1234, 4'b0000, 1, 4'b1110, 4, 1, 0);
        tbl[3]  = v(16'h1234, 4'b0000, 1, 4'b1110, 4, 1, 1);
        tbl[4]  = v(16'h1234, 4'b0000, 1, 4'b1101, 3, 1, 0);
        tbl[5]  = v(16'h1234, 4'b0000, 1, 4'b1101, 3, 1, 0);
        tbl[6]  = v(16'h1234, 4'b0000, 1, 4'b1101, 3, 1, 0);
        tbl[7]  = v(16'h1234, 4'b0000, 1, 4'b1101, 3, 1, 1);
        tbl[8]  = v(16'h1234, 4'b0000, 1, 4'b1011, 2, 1, 0);
        tbl[9]  = v(16'h1234, 4'b0000, 1, 4'b1011, 2, 1, 0);
        tbl[10] = v(16'h1234, 4'b0000, 1, 4'b1011, 2, 1, 0);
        tbl[11] = v(16'h1234, 4'b0000, 1, 4'b1011, 2, 1, 1);
        tbl[12] = v(16'h1234, 4'b0000, 1, 4'b0111, 1, 1, 0);
        tbl[13] = v(16'h1234, 4'b0000, 1, 4'b0111, 1, 1, 0);
        tbl[14] = v(16'h1234, 4'b0000, 1, 4'b0111, 1, 1, 0);
        tbl[15] = v(16'h1234, 4'b0000, 1, 4'b0111, 1, 1, 1);
        tbl[16] = v(16'h1234, 4'b0100, 1, 4'b1110, 4, 1, 0);
        tbl[17] = v(16'h1234, 4'b0100, 1, 4'b1110, 4, 1, 0);
        tbl[18] = v(16'h1234, 4'b0100, 1, 4'b1110, 4, 1, 0);
        tbl[19] = v(16'h1234, 4'b0100, 1, 4'b1110, 4, 1, 1);
        tbl[20] = v(16'h1234, 4'b0100, 1, 4'b1101, 3, 1, 0);
        tbl[21] = v(16'h1234, 4'b0100, 1, 4'b1101, 3, 1, 0);
        tbl[22] = v(16'h1234, 4'b0100, 1, 4'b1101, 3, 1, 0);
        tbl[23] = v(16'h1234, 4'b0100, 1, 4'b1101, 3, 1, 1);
        tbl[24] = v(16'h1234, 4'b0100, 1, 4'b1011, 2, 0, 0);
        tbl[25] = v(16'h1234, 4'b0100, 1, 4'b1011, 2, 0, 0);
        tbl[26] = v(16'h1234, 4'b0100, 1, 4'b1011, 2, 0, 0);
        tbl[27] = v(16'h1234, 4'b0100, 1, 4'b1011, 2, 0, 1);
        tbl[28] = v(16'h1234, 4'b0100, 1, 4'b0111, 1, 1, 0);
        tbl[29] = v(16'h1234, 4'b0100, 1, 4'b0111, 1, 1, 0);
        tbl[30] = v(16'h1234, 4'b0100, 1, 4'b0111, 1, 1, 0);
        tbl[31] = v(16'h1234, 4'b0100, 1, 4'b0111, 1, 1, 1);
        tbl[32] = v(16'h1234, 4'b0100, 1, 4'b1110, 4, 1, 0);
        tbl[33] = v(16'h1234, 4'b0100, 1, 4'b1110, 4, 1, 0);
        for (int i = 34; i < 44; i++)
            tbl[i] = v(16'h1234, 4'b0100, 0, 4'b1111, 0, 1, 0);
        tbl[44] = v(16'h1234, 4'b0100, 1, 4'b1110, 4, 1, 0);
        tbl[45] = v(16'h1234, 4'b0100, 1, 4'b1110, 4, 1, 1);
        tbl[46] = v(16'h1234, 4'b0100, 1, 4'b1101, 3, 1, 0);
        tbl[47] = v(16'h1294, 4'b0100, 1, 4'b1101, 9, 1, 0);

        rst_n = 1'b0;
        en    = 1'b0;
        in    = 16'h1234;
        dp_in = 4'b0000;
        #12;
        chk("reset_an",    0, an,    4'b1111);
        chk("reset_digit", 0, digit, 4'h0);
        chk("reset_dp",    0, dp,    1'b1);
        chk("reset_tick",  0, tick,  1'b0);

        en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 48; i++) begin
            in    = tbl[i].in;
            dp_in = tbl[i].dp_in;
            en    = tbl[i].en;
            @(posedge clk);
            #1;
            chk("scan_an",    i + 1, an,    tbl[i].an);
            chk("scan_digit", i + 1, digit, tbl[i].digit);
            chk("scan_dp",    i + 1, dp,    tbl[i].dp);
            chk("scan_tick",  i + 1, tick,  tbl[i].tick);
        end

        // move into slot 2, then reset asynchronously between edges
        in    = 16'h1234;
        dp_in = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_an", 0, an, 4'b1011);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_an",    0, an,    4'b1111);
        chk("async_rst_digit", 0, digit, 4'h0);
        chk("async_rst_dp",    0, dp,    1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            chk("post_rst_an",    k, an,    (k < 5) ? 4'b1110 : 4'b1101);
            chk("post_rst_digit", k, digit, (k < 5) ? 4'h4 : 4'h3);
            chk("post_rst_tick",  k, tick,  (k == 4) ? 1'b1 : 1'b0);
        end

        blk_dg[0] = 4'h0; blk_dg[1] = 4'h5; blk_dg[2] = 4'h0; blk_dg[3] = 4'h0;
        blk_an[0] = 4'b1110;
        blk_an[1] = 4'b1101;
`ifdef DIGIT_SCAN_BLANK_EN
        blk_an[2] = 4'b1111;
        blk_an[3] = 4'b1111;
`else
        blk_an[2] = 4'b1011;
        blk_an[3] = 4'b0111;
`endif
        @(negedge clk);
        rst_n = 1'b0;
        in    = 16'h0050;
        dp_in = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 16; n++) begin
            @(posedge clk);
            #1;
            chk("blank_an",    n + 1, an,    blk_an[n / 4]);
            chk("blank_digit", n + 1, digit, blk_dg[n / 4]);
            chk("blank_tick",  n + 1, tick,  (n % 4 == 3) ? 1'b1 : 1'b0);
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
